// File: rtl/sdram_frame_reader.sv
// Avalon-MM read master that fetches a width x height region of 16-bit pixels
// row by row and replays it as an Avalon-ST stream with sop/eop markers.
module sdram_frame_reader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] aso_data,
    output logic              aso_valid,
    input  logic              aso_ready,
    output logic              aso_sop,
    output logic              aso_eop,
    output logic [1:0]        dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    logic [15:0]       width_q, height_q, col_q, row_q;
    logic [ADDR_W-1:0] stride_q, row_base_q, addr_q;
    logic              read_q, busy_q, done_q;
    logic [31:0]       total_q, out_cnt_q;
    logic [CW-1:0]     outst_q, count_q, outst_d, count_d;
    logic [CW:0]       credit_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic accept, push, pop, last_addr, room_d;

    // Valid/ready: a read transfers when avm_read & ~avm_waitrequest; a pixel
    // transfers when aso_valid & aso_ready. Both sides hold their payload until then.
    assign accept    = read_q & ~avm_waitrequest;
    assign push      = avm_readdatavalid;
    assign pop       = aso_valid & aso_ready;
    assign last_addr = (col_q == width_q - 16'd1) && (row_q == height_q - 16'd1);

    // Credit after this cycle's traffic decides whether the next request may go out.
    always_comb begin
        outst_d = outst_q;
        if (accept && !push)
            outst_d = outst_q + CW'(1);
        else if (!accept && push)
            outst_d = outst_q - CW'(1);
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
        credit_d = {1'b0, outst_d} + {1'b0, count_d};
    end

    assign room_d = (credit_d < DEPTH_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            outst_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            outst_q <= outst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= avm_readdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            total_q    <= '0;
            out_cnt_q  <= '0;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop)
                out_cnt_q <= out_cnt_q + 32'd1;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        width_q    <= width;
                        height_q   <= height;
                        stride_q   <= stride;
                        row_base_q <= base_addr;
                        addr_q     <= base_addr;
                        col_q      <= '0;
                        row_q      <= '0;
                        total_q    <= 32'(width) * 32'(height);
                        out_cnt_q  <= '0;
                        if (width == 16'd0 || height == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            busy_q  <= 1'b1;
                            read_q  <= room_d;
                        end
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        if (last_addr) begin
                            read_q  <= 1'b0;
                            state_q <= S_DRAIN;
                        end else begin
                            if (col_q == width_q - 16'd1) begin
                                col_q      <= '0;
                                row_q      <= row_q + 16'd1;
                                row_base_q <= row_base_q + stride_q;
                                addr_q     <= row_base_q + stride_q;
                            end else begin
                                col_q  <= col_q + 16'd1;
                                addr_q <= addr_q + ADDR_W'(2);
                            end
                            read_q <= room_d;
                        end
                    end else if (!read_q) begin
                        read_q <= room_d;
                    end
                end
                S_DRAIN: begin
                    if (outst_q == '0 && count_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign aso_valid   = (count_q != '0);
    assign aso_data    = mem_q[rd_ptr_q];
    assign aso_sop     = aso_valid && (out_cnt_q == 32'd0);
    assign aso_eop     = aso_valid && (out_cnt_q == total_q - 32'd1);
    assign dbg_state   = state_q;

endmodule
